cond_exec_sequencer: RTL and testbench
======================================

Name: cond_exec_sequencer

Overview:
- Multicycle sequencer for conditional execution: owns the architectural NZCV flags register and evaluates each instruction's 4-bit condition field against it.
- Starts the ALU only for instructions whose condition passes, then issues gated register, memory and PC write strobes.
- Sits between decode (valid/ready) and the ALU/register file; keeps executed and squashed instruction counts.

Parameters:
- CNT_W, 16, width of the executed and squashed counters (counters saturate).
- WAIT_MAX, 15, maximum cycles in EXEC without alu_done before the instruction is abandoned.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  sequencer can accept an instruction.
- cond  in  4  condition field.
- flag_w  in  2  [1] updates N,Z; [0] updates C,V.
- reg_w  in  1  instruction writes the register file.
- mem_w  in  1  instruction writes memory.
- pc_s  in  1  instruction writes the PC (branch).
- no_write  in  1  compare-type instruction; suppresses register write only.
- alu_start  out  1  one-cycle pulse that starts the ALU.
- alu_done  in  1  ALU result and alu_flags are valid.
- alu_flags  in  4  {N,Z,C,V} from the ALU.
- reg_write  out  1  register file write strobe.
- mem_write  out  1  memory write strobe.
- pc_src  out  1  PC update strobe.
- flags  out  4  architectural {N,Z,C,V}.
- cond_ex  out  1  condition result, valid in EVAL.
- undef  out  1  one-cycle pulse when cond=4'b1111.
- timeout  out  1  one-cycle pulse on ALU timeout.
- exec_count  out  CNT_W  committed instructions.
- squash_count  out  CNT_W  squashed instructions.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE; flags=0000; counters=0.
  - All strobes, undef and timeout at 0.
  - An in-flight instruction is dropped with no strobes and no flag update.
- FSM states: IDLE, EVAL, EXEC, COMMIT.
  - IDLE: in_ready=1 in IDLE only. When in_valid&in_ready, capture all fields, go to EVAL.
  - EVAL (1 cycle): cond_ex is combinational from the captured cond and the flags register.
    - Pass: go to EXEC.
    - Fail: squash_count+1 (saturating), return to IDLE.
    - cond=1111: undef=1, counted as a squash.
  - EXEC: alu_start=1 in the first EXEC cycle only. A wait counter starts at 0 on entry and increments each cycle.
    - alu_done=1 (first cycle allowed): latch alu_flags, go to COMMIT.
    - Counter reaches WAIT_MAX with no done: timeout=1, return to IDLE. No commit, no flag change, no count.
  - COMMIT (1 cycle):
    - Strobes: reg_write=reg_w&~no_write; mem_write=mem_w; pc_src=pc_s.
    - Flags: if flag_w[1], N,Z←latched; if flag_w[0], C,V←latched.
    - exec_count+1 (saturating); next state IDLE.
- Condition table, with ge=(N==V):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~(C&~Z)
  - 1010 ge; 1011 ~ge
  - 1100 ~Z&ge; 1101 ~(~Z&ge)
  - 1110 1; 1111 0 (undef)
- Latency:
  - Handshake at cycle T, EVAL at T+1, alu_start at T+2.
  - With alu_done at T+2, COMMIT at T+3 and the next accept at T+4.
  - Squash path: accept at T, next accept at T+2.
- Back-to-back instructions: flags written in COMMIT are visible in the next instruction's EVAL, so no forwarding is needed.
- alu_done outside EXEC is ignored.
- The cond_ex output is 0 outside EVAL.
- Inputs are sampled only at the handshake; changes afterwards have no effect.

Test Plan:
- Reset, then issue ADDS cond=1110 flag_w=11 reg_w=1 with alu_done at T+2 and alu_flags=0100 → alu_start at T+2; reg_write=1 at T+3; flags=0100 from T+4; exec_count=1.
- With flags=0100, issue BEQ cond=0000 pc_s=1, then BNE cond=0001 → BEQ: pc_src pulses. BNE: no alu_start; squash_count=1; in_ready high at T+2.
- CMP with no_write=1, flag_w=11, alu_flags=1000, then GE (cond=1010) → reg_write stays 0; flags=1000; GE squashed (N≠V).
- flag_w=01 with alu_flags=1111 from flags=0000 → flags=0011 (N,Z unchanged).
- alu_done never asserted → timeout pulse after 15 EXEC cycles; no strobes; flags and counters unchanged; in_ready=1 the next cycle.
- Cond=1111 → undef pulse in EVAL; squash_count increments. Separately, reset_n low during EXEC → state IDLE and no COMMIT strobes after release.

Source files
------------

// File: rtl/cond_exec_sequencer_if.sv
// ---------------------------------------------------------------------------
// cond_exec_sequencer_if
// Purpose : bundles the decode handshake, ALU control and commit strobes of
//           the conditional-execution sequencer into one interface.
// Signals :
//   in_valid/in_ready          decode handshake
//   cond, flag_w, reg_w, mem_w,
//   pc_s, no_write             instruction fields, sampled at the handshake
//   alu_start/alu_done,
//   alu_flags                  ALU control and returned {N,Z,C,V}
//   reg_write, mem_write,
//   pc_src                     gated commit strobes
//   flags, cond_ex, undef,
//   timeout                    status outputs
//   exec_count, squash_count   saturating instruction counters
// Modports: master = decode/ALU side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface cond_exec_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       cond;
  logic [1:0]       flag_w;
  logic             reg_w;
  logic             mem_w;
  logic             pc_s;
  logic             no_write;
  logic             alu_start;
  logic             alu_done;
  logic [3:0]       alu_flags;
  logic             reg_write;
  logic             mem_write;
  logic             pc_src;
  logic [3:0]       flags;
  logic             cond_ex;
  logic             undef;
  logic             timeout;
  logic [CNT_W-1:0] exec_count;
  logic [CNT_W-1:0] squash_count;

  modport master (
    output in_valid, cond, flag_w, reg_w, mem_w, pc_s, no_write,
           alu_done, alu_flags,
    input  in_ready, alu_start, reg_write, mem_write, pc_src, flags,
           cond_ex, undef, timeout, exec_count, squash_count
  );

  modport slave (
    input  in_valid, cond, flag_w, reg_w, mem_w, pc_s, no_write,
           alu_done, alu_flags,
    output in_ready, alu_start, reg_write, mem_write, pc_src, flags,
           cond_ex, undef, timeout, exec_count, squash_count
  );
endinterface

// File: rtl/cond_exec_sequencer.sv
// ---------------------------------------------------------------------------
// cond_exec_sequencer
// Purpose : multicycle sequencer for conditionally executed instructions.
//           Holds the architectural NZCV register, evaluates each captured
//           condition field against it, starts the ALU only for passing
//           instructions and issues gated write strobes in COMMIT.
// Ports   :
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      cond_exec_sequencer_if.slave (handshake, ALU, strobes, status)
// Parameters:
//   CNT_W    width of the saturating executed/squashed counters
//   WAIT_MAX EXEC cycles allowed without alu_done before abandoning
// ---------------------------------------------------------------------------
module cond_exec_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input logic                  clk,
  input logic                  reset_n,
  cond_exec_sequencer_if.slave bus
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_EXEC   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         flags_q, flags_d;
  logic [3:0]         cond_q, cond_d;
  logic [1:0]         flag_w_q, flag_w_d;
  logic               reg_w_q, reg_w_d;
  logic               mem_w_q, mem_w_d;
  logic               pc_s_q, pc_s_d;
  logic               no_write_q, no_write_d;
  logic [3:0]         alu_flags_q, alu_flags_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   exec_q, exec_d;
  logic [CNT_W-1:0]   squash_q, squash_d;

  // Odd condition codes are the inverse of the even code below them; this
  // also makes 4'b1111 evaluate to 0 (the "always" case inverted).
  function automatic logic cond_pass_f(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, ge, base;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    ge = (n == v);
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = ge;
      3'd6:    base = ~z & ge;
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  logic cond_pass;
  assign cond_pass = cond_pass_f(cond_q, flags_q);

  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    cond_d       = cond_q;
    flag_w_d     = flag_w_q;
    reg_w_d      = reg_w_q;
    mem_w_d      = mem_w_q;
    pc_s_d       = pc_s_q;
    no_write_d   = no_write_q;
    alu_flags_d  = alu_flags_q;
    wait_d       = wait_q;
    exec_d       = exec_q;
    squash_d     = squash_q;

    bus.in_ready  = 1'b0;
    bus.alu_start = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem_write = 1'b0;
    bus.pc_src    = 1'b0;
    bus.cond_ex   = 1'b0;
    bus.undef     = 1'b0;
    bus.timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          cond_d     = bus.cond;
          flag_w_d   = bus.flag_w;
          reg_w_d    = bus.reg_w;
          mem_w_d    = bus.mem_w;
          pc_s_d     = bus.pc_s;
          no_write_d = bus.no_write;
          state_d    = S_EVAL;
        end
      end

      S_EVAL: begin
        bus.cond_ex = cond_pass;
        bus.undef   = (cond_q == 4'hF);
        if (cond_pass) begin
          wait_d  = '0;
          state_d = S_EXEC;
        end else begin
          if (squash_q != {CNT_W{1'b1}}) begin
            squash_d = squash_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end

      S_EXEC: begin
        bus.alu_start = (wait_q == '0);
        if (bus.alu_done) begin
          alu_flags_d = bus.alu_flags;
          state_d     = S_COMMIT;
        end else if (wait_q == WAIT_LAST) begin
          // Abandon: no commit, flags and counters left untouched.
          bus.timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      S_COMMIT: begin
        bus.reg_write = reg_w_q & ~no_write_q;
        bus.mem_write = mem_w_q;
        bus.pc_src    = pc_s_q;
        if (flag_w_q[1]) begin
          flags_d[3:2] = alu_flags_q[3:2];
        end
        if (flag_w_q[0]) begin
          flags_d[1:0] = alu_flags_q[1:0];
        end
        if (exec_q != {CNT_W{1'b1}}) begin
          exec_d = exec_q + 1'b1;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      cond_q      <= '0;
      flag_w_q    <= '0;
      reg_w_q     <= 1'b0;
      mem_w_q     <= 1'b0;
      pc_s_q      <= 1'b0;
      no_write_q  <= 1'b0;
      alu_flags_q <= '0;
      wait_q      <= '0;
      exec_q      <= '0;
      squash_q    <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_q      <= cond_d;
      flag_w_q    <= flag_w_d;
      reg_w_q     <= reg_w_d;
      mem_w_q     <= mem_w_d;
      pc_s_q      <= pc_s_d;
      no_write_q  <= no_write_d;
      alu_flags_q <= alu_flags_d;
      wait_q      <= wait_d;
      exec_q      <= exec_d;
      squash_q    <= squash_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.exec_count   = exec_q;
  assign bus.squash_count = squash_q;

endmodule

// File: tb/tb_cond_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_sequencer
// Purpose : self-checking bench for cond_exec_sequencer. A vector table
//           walks through the flag/condition scenarios, a sweep covers every
//           condition code against every flag value, and hand-written
//           sequences cover timeout and reset during EXEC. Strobe, undef and
//           timeout pulses are checked through a scoreboard queue.
// ---------------------------------------------------------------------------
module tb_cond_exec_sequencer;
  localparam int CNT_W    = 16;
  localparam int WAIT_MAX = 15;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cond_exec_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cond_exec_sequencer #(
    .CNT_W   (CNT_W),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]       m_flags  = 4'h0;
  logic [CNT_W-1:0] m_exec   = '0;
  logic [CNT_W-1:0] m_squash = '0;

  typedef struct packed {
    logic rw;
    logic mw;
    logic ps;
    logic ud;
    logic to;
  } ev_t;

  ev_t sb_q[$];
  ev_t act_ev;
  ev_t exp_ev;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       rw;
    logic       mw;
    logic       ps;
    logic       nw;
    logic [3:0] af;
    int         delay;
    logic       exp_pass;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference condition table written out code by code.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !(cf && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Scoreboard consumer: every visible pulse must match the next expected one.
  always @(negedge clk) begin
    if (reset_n && (bus.reg_write || bus.mem_write || bus.pc_src || bus.undef || bus.timeout)) begin
      act_ev = '{rw: bus.reg_write, mw: bus.mem_write, ps: bus.pc_src, ud: bus.undef, to: bus.timeout};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got event %b, expected none", act_ev);
      end else begin
        exp_ev = sb_q.pop_front();
        if (act_ev !== exp_ev) begin
          n_fail++;
          $display("FAIL sb_event: got %b, expected %b", act_ev, exp_ev);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_flags"}, bus.flags, m_flags);
    chk({tag, "_exec"}, bus.exec_count, m_exec);
    chk({tag, "_squash"}, bus.squash_count, m_squash);
  endtask

  // Called one step after a rising edge with the DUT in IDLE; returns in IDLE.
  task automatic issue(input logic [3:0] c, input logic [1:0] fw, input logic rw,
                       input logic mw, input logic ps, input logic nw,
                       input logic [3:0] af, input int delay,
                       input logic exp_pass, input logic [3:0] exp_flags);
    bit   committed;
    logic exp_to;
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.cond     = c;
    bus.flag_w   = fw;
    bus.reg_w    = rw;
    bus.mem_w    = mw;
    bus.pc_s     = ps;
    bus.no_write = nw;
    bus.alu_done = 1'b0;
    tick();
    // EVAL: scramble fields and wiggle alu_done; neither may have any effect.
    bus.in_valid  = 1'b0;
    bus.cond      = 4'($urandom);
    bus.flag_w    = 2'($urandom);
    bus.reg_w     = 1'($urandom);
    bus.mem_w     = 1'($urandom);
    bus.pc_s      = 1'($urandom);
    bus.no_write  = 1'($urandom);
    bus.alu_done  = 1'b1;
    bus.alu_flags = 4'($urandom);
    chk("in_ready_eval", bus.in_ready, 0);
    chk("cond_ex", bus.cond_ex, exp_pass);
    chk("undef", bus.undef, c == 4'hF);
    if (c == 4'hF) sb_q.push_back('{rw: 1'b0, mw: 1'b0, ps: 1'b0, ud: 1'b1, to: 1'b0});
    if (!exp_pass) begin
      bus.alu_done = 1'b0;
      tick();
      m_squash++;
      chk("squash_alu_start", bus.alu_start, 0);
      chk("squash_cond_ex", bus.cond_ex, 0);
      chk_idle("squash");
    end else begin
      committed = 1'b0;
      for (int k = 0; k < WAIT_MAX; k++) begin
        tick();
        chk("alu_start", bus.alu_start, k == 0);
        bus.alu_done  = (k == delay);
        bus.alu_flags = (k == delay) ? af : 4'($urandom);
        exp_to = (delay < 0) && (k == WAIT_MAX - 1);
        #1;
        chk("timeout", bus.timeout, exp_to);
        if (exp_to) sb_q.push_back('{rw: 1'b0, mw: 1'b0, ps: 1'b0, ud: 1'b0, to: 1'b1});
        if (k == delay) begin
          committed = 1'b1;
          break;
        end
      end
      if (committed) begin
        if ((rw && !nw) || mw || ps)
          sb_q.push_back('{rw: rw && !nw, mw: mw, ps: ps, ud: 1'b0, to: 1'b0});
        tick();
        bus.alu_done = 1'b0;
        chk("commit_reg_write", bus.reg_write, rw && !nw);
        chk("commit_mem_write", bus.mem_write, mw);
        chk("commit_pc_src", bus.pc_src, ps);
        chk("commit_flags_old", bus.flags, m_flags);
        tick();
        m_exec++;
        m_flags = exp_flags;
        chk_idle("commit");
      end else begin
        bus.alu_done = 1'b0;
        tick();
        chk("to_reg_write", bus.reg_write, 0);
        chk_idle("timeout");
      end
    end
    $display("instr cond=%h fw=%b af=%b delay=%0d -> flags=%b exec=%0d squash=%0d",
             c, fw, af, delay, bus.flags, bus.exec_count, bus.squash_count);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.cond      = 4'h0;
    bus.flag_w    = 2'b00;
    bus.reg_w     = 1'b0;
    bus.mem_w     = 1'b0;
    bus.pc_s      = 1'b0;
    bus.no_write  = 1'b0;
    bus.alu_done  = 1'b0;
    bus.alu_flags = 4'h0;

    //          cond   fw     rw    mw    ps    nw    af       dly pass  flags
    vecs[0] = '{4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100,  0, 1'b1, 4'b0100}; // ADDS
    vecs[1] = '{4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011,  0, 1'b1, 4'b0100}; // BEQ
    vecs[2] = '{4'h1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000,  0, 1'b0, 4'b0100}; // BNE
    vecs[3] = '{4'hE, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1000,  2, 1'b1, 4'b1000}; // CMP
    vecs[4] = '{4'hA, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000,  0, 1'b0, 4'b1000}; // GE
    vecs[5] = '{4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000,  1, 1'b1, 4'b0000}; // store, clear
    vecs[6] = '{4'hE, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111,  0, 1'b1, 4'b0011}; // C,V only
    vecs[7] = '{4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, -1, 1'b1, 4'b0011}; // timeout
    vecs[8] = '{4'hF, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000,  0, 1'b0, 4'b0011}; // undef

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_flags", bus.flags, 0);
    chk("rst_exec", bus.exec_count, 0);
    chk("rst_squash", bus.squash_count, 0);
    chk("rst_strobes", {bus.alu_start, bus.reg_write, bus.mem_write, bus.pc_src, bus.undef, bus.timeout}, 0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_cond_ex", bus.cond_ex, 0);

    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].cond, vecs[i].fw, vecs[i].rw, vecs[i].mw, vecs[i].ps, vecs[i].nw,
            vecs[i].af, vecs[i].delay, vecs[i].exp_pass, vecs[i].exp_flags);
    end

    // Every condition code against every flag value.
    for (int f = 0; f < 16; f++) begin
      issue(4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'(f), 0, 1'b1, 4'(f));
      for (int c = 0; c < 16; c++) begin
        issue(4'(c), 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom), int'($urandom_range(0, 3)),
              ref_cond(4'(c), 4'(f)), 4'(f));
      end
    end

    // Reset asserted while waiting in EXEC: instruction dropped silently.
    chk("rx_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.cond     = 4'hE;
    bus.flag_w   = 2'b11;
    bus.reg_w    = 1'b1;
    bus.mem_w    = 1'b1;
    bus.pc_s     = 1'b1;
    bus.no_write = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rx_alu_start", bus.alu_start, 1);
    tick();
    reset_n = 1'b0;
    bus.alu_done  = 1'b1;
    bus.alu_flags = 4'b1111;
    #1;
    m_flags  = 4'h0;
    m_exec   = '0;
    m_squash = '0;
    chk_idle("rx_in_reset");
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rx_no_strobes", {bus.alu_start, bus.reg_write, bus.mem_write, bus.pc_src}, 0);
      chk_idle("rx_after");
    end
    bus.alu_done = 1'b0;
    $display("reset during EXEC -> flags=%b exec=%0d squash=%0d",
             bus.flags, bus.exec_count, bus.squash_count);

    tick();
    chk("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
